ifid_stall_pipe: RTL

IFID_STALL_PIPE -- requirements
Module: ifid_stall_pipe

---
 rtl/ifid_stall_pipe_if.sv | 39 +++
 rtl/ifid_stall_pipe.sv | 100 ++++++++++
 2 files changed

// File: rtl/ifid_stall_pipe_if.sv
// Front-end pipeline bus: hazard/redirect controls into the PC, IF/ID and ID/EX registers.
// The stall_cnt signal exists only when STALL_CNT_EN is defined.
interface ifid_stall_pipe_if #(
    parameter int unsigned CTRL_W = 8
);
    logic              PcWrite;
    logic              Ifid_write;
    logic              mux_sel;
    logic              branch_taken;
    logic [31:0]       branch_target;
    logic [31:0]       instr_in;
    logic [CTRL_W-1:0] ctrl_in;

    logic [31:0]       pc_out;
    logic [31:0]       ifid_pc;
    logic [31:0]       ifid_instr;
    logic              ifid_valid;
    logic [CTRL_W-1:0] idex_ctrl;
    logic              idex_valid;
`ifdef STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    modport master (
        output PcWrite, Ifid_write, mux_sel, branch_taken, branch_target, instr_in, ctrl_in,
        input  pc_out, ifid_pc, ifid_instr, ifid_valid, idex_ctrl, idex_valid
`ifdef STALL_CNT_EN
        , input stall_cnt
`endif
    );

    modport slave (
        input  PcWrite, Ifid_write, mux_sel, branch_taken, branch_target, instr_in, ctrl_in,
        output pc_out, ifid_pc, ifid_instr, ifid_valid, idex_ctrl, idex_valid
`ifdef STALL_CNT_EN
        , output stall_cnt
`endif
    );
endinterface

// File: rtl/ifid_stall_pipe.sv
// PC, IF/ID and ID/EX registers with load-use stall, bubble insertion and branch flush.
// Optional saturating stall-cycle counter enabled by defining STALL_CNT_EN.
module ifid_stall_pipe #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CTRL_W   = 8
) (
    input logic              clk,
    input logic              reset,
    ifid_stall_pipe_if.slave bus
);
    localparam logic [31:0] NopInstr = 32'h0000_0013;

    logic [31:0]       pc_q, pc_d;
    logic [31:0]       ifid_pc_q, ifid_pc_d;
    logic [31:0]       ifid_instr_q, ifid_instr_d;
    logic              ifid_valid_q, ifid_valid_d;
    logic [CTRL_W-1:0] idex_ctrl_q, idex_ctrl_d;
    logic              idex_valid_q, idex_valid_d;

    // Redirect wins over any stall request in the same cycle.
    always_comb begin
        pc_d = pc_q;
        if (bus.branch_taken) begin
            pc_d = {bus.branch_target[31:2], 2'b00};
        end else if (bus.PcWrite) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_comb begin
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        if (bus.branch_taken) begin
            ifid_pc_d    = 32'd0;
            ifid_instr_d = NopInstr;
            ifid_valid_d = 1'b0;
        end else if (bus.Ifid_write) begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = bus.instr_in;
            ifid_valid_d = 1'b1;
        end
    end

    always_comb begin
        idex_ctrl_d  = bus.ctrl_in;
        idex_valid_d = ifid_valid_q;
        if (bus.branch_taken || bus.mux_sel) begin
            idex_ctrl_d  = '0;
            idex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            ifid_pc_q    <= 32'd0;
            ifid_instr_q <= NopInstr;
            ifid_valid_q <= 1'b0;
            idex_ctrl_q  <= '0;
            idex_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            idex_ctrl_q  <= idex_ctrl_d;
            idex_valid_q <= idex_valid_d;
        end
    end

    assign bus.pc_out     = pc_q;
    assign bus.ifid_pc    = ifid_pc_q;
    assign bus.ifid_instr = ifid_instr_q;
    assign bus.ifid_valid = ifid_valid_q;
    assign bus.idex_ctrl  = idex_ctrl_q;
    assign bus.idex_valid = idex_valid_q;

`ifdef STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Counts cycles where the PC is held without a redirect; sticks at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!bus.PcWrite && !bus.branch_taken && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`endif
endmodule
